// File: rtl/ik_pkg.sv
// Shared fixed-point definitions for the IK datapath (Q4.22 by default).
package ik_pkg;
  localparam int WIDTH = 27;
  localparam int FRAC  = 22;

  typedef logic signed [WIDTH-1:0]   fixed_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;

  localparam fixed_t SAT_MAX = fixed_t'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam fixed_t SAT_MIN = fixed_t'(-(64'sd1 <<< (WIDTH - 1)));
endpackage

// File: rtl/mult_lane.sv
// One multiplier lane: register operands, register the full product,
// then register the round-half-up, saturated fixed-point result.
module mult_lane #(
  parameter int WIDTH = ik_pkg::WIDTH,
  parameter int FRAC  = ik_pkg::FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] RND     = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (WIDTH - 1));

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [PW-1:0]    rnd_sum;
  logic signed [PW-1:0]    rnd_val;
  logic signed [WIDTH-1:0] sat_val;

  // Full 2*WIDTH product cannot overflow when the rounding constant is added.
  always_comb begin
    rnd_sum = prod_q + RND;
    rnd_val = rnd_sum >>> FRAC;
    if (rnd_val > SAT_MAX) begin
      sat_val = SAT_MAX[WIDTH-1:0];
    end else if (rnd_val < SAT_MIN) begin
      sat_val = SAT_MIN[WIDTH-1:0];
    end else begin
      sat_val = rnd_val[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      y      <= '0;
    end else if (en) begin
      a_q    <= a;
      b_q    <= b;
      prod_q <= PW'(a_q) * PW'(b_q);
      y      <= sat_val;
    end
  end
endmodule

// File: rtl/array_mult9.sv
// NLANES independent 3-stage fixed-point multiplier lanes sharing clock,
// reset and enable; no cross-lane logic.
module array_mult9 #(
  parameter int NLANES = 12,
  parameter int WIDTH  = ik_pkg::WIDTH,
  parameter int FRAC   = ik_pkg::FRAC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NLANES-1:0][WIDTH-1:0] dataa,
  input  logic [NLANES-1:0][WIDTH-1:0] datab,
  output logic [NLANES-1:0][WIDTH-1:0] result
);
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    mult_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .en (en),
      .a  (dataa[i]),
      .b  (datab[i]),
      .y  (result[i])
    );
  end
endmodule

// File: tb/tb_array_mult9.sv
// Bench for array_mult9: directed test-plan cases plus randomized traffic
// against an arithmetic reference with a queue-based latency model.
module tb_array_mult9;
  import ik_pkg::*;

  localparam int NL = 12;
  localparam int W  = WIDTH;

  typedef logic [NL-1:0][W-1:0] vec_t;

  logic clk;
  logic rst;
  logic en;
  vec_t dataa;
  vec_t datab;
  vec_t result;

  int checks;
  int passes;

  // Expected-result pipeline: outputs still to appear, plus current output.
  vec_t exp_q[$];
  vec_t exp_cur;

  array_mult9 #(.NLANES(NL), .WIDTH(W), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .dataa (dataa),
    .datab (datab),
    .result(result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic fixed_t ref_lane(input fixed_t a, input fixed_t b);
    longint p;
    longint r;
    p = longint'(a) * longint'(b);
    r = (p + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    if (r > longint'(SAT_MAX)) r = longint'(SAT_MAX);
    if (r < longint'(SAT_MIN)) r = longint'(SAT_MIN);
    return fixed_t'(r);
  endfunction

  function automatic vec_t ref_vec(input vec_t va, input vec_t vb);
    vec_t v;
    for (int i = 0; i < NL; i++) v[i] = ref_lane(fixed_t'(va[i]), fixed_t'(vb[i]));
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_cur = '0;
  endtask

  // ---------------- drivers ----------------
  // One clock: inputs already driven; model advances on enabled, non-reset edges.
  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    if (e && rst) begin
      exp_q.push_back(ref_vec(dataa, datab));
      exp_cur = exp_q.pop_front();
    end
    #1;
  endtask

  function automatic fixed_t rnd_op();
    fixed_t v;
    case ($urandom_range(0, 3))
      0: v = fixed_t'($urandom);
      1: v = fixed_t'($signed($urandom_range(0, 1 << 24)) - (1 << 23));
      2: v = ($urandom_range(0, 1) != 0) ? SAT_MAX : SAT_MIN;
      default: v = fixed_t'($signed($urandom_range(0, 2)) * 4194304 - 4194304);
    endcase
    return v;
  endfunction

  task automatic drive_random();
    for (int i = 0; i < NL; i++) begin
      dataa[i] = rnd_op();
      datab[i] = rnd_op();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; dataa = '1; datab = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== '0) $display("FAIL reset_hold: result=%h expected=0", result);
    else passes++;
    dataa = '0; datab = '0; en = 1'b0;
    rst = 1'b1;
    model_reset();
    step(1'b0);
    checks++;
    if (result !== '0) $display("FAIL reset_release: result=%h expected=0", result);
    else passes++;
  endtask

  task automatic test_identity();
    for (int i = 0; i < NL; i++) begin
      dataa[i] = 27'd4194304;
      datab[i] = 27'd4194304;
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (result[i] !== ((k == 3) ? 27'd4194304 : 27'd0))
          $display("FAIL identity edge%0d lane%0d: result=%0d expected=%0d", k, i,
                   $signed(result[i]), (k == 3) ? 4194304 : 0);
        else passes++;
      end
    end
  endtask

  task automatic test_signed();
    fixed_t exp_l[NL];
    dataa = '0;
    for (int i = 0; i < NL; i++) begin
      datab[i] = fixed_t'($urandom);
      exp_l[i] = '0;
    end
    dataa[0] = -27'sd6291456; datab[0] = 27'sd8388608; exp_l[0] = -27'sd12582912;
    dataa[1] = 27'sd2097152;  datab[1] = 27'sd2097152; exp_l[1] = 27'sd1048576;
    repeat (3) step(1'b1);
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (result[i] !== exp_l[i])
        $display("FAIL signed lane%0d: result=%0d expected=%0d", i, $signed(result[i]), exp_l[i]);
      else passes++;
    end
  endtask

  task automatic test_rounding();
    fixed_t ta[5] = '{27'sd2097152, -27'sd2097152, 27'sd1, -27'sd1, -27'sd6291456};
    fixed_t te[5] = '{27'sd1, 27'sd0, 27'sd0, 27'sd0, -27'sd1};
    dataa = '0; datab = '0;
    for (int i = 0; i < 5; i++) begin
      dataa[i] = ta[i];
      datab[i] = 27'sd1;
    end
    repeat (3) step(1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (result[i] !== te[i])
        $display("FAIL rounding lane%0d: result=%0d expected=%0d", i, $signed(result[i]), te[i]);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    fixed_t ta[4] = '{27'sd33554432, -27'sd33554432, -27'sd67108864, -27'sd67108864};
    fixed_t tb[4] = '{27'sd16777216, 27'sd16777216, -27'sd67108864, 27'sd4194304};
    fixed_t te[4] = '{27'sd67108863, -27'sd67108864, 27'sd67108863, -27'sd67108864};
    dataa = '0; datab = '0;
    for (int i = 0; i < 4; i++) begin
      dataa[i + 8] = ta[i];
      datab[i + 8] = tb[i];
    end
    repeat (3) step(1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result[i + 8] !== te[i])
        $display("FAIL saturation lane%0d: result=%0d expected=%0d", i + 8,
                 $signed(result[i + 8]), te[i]);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      drive_random();
      step($urandom_range(0, 3) != 0);
      checks++;
      if (result !== exp_cur) $display("FAIL random cyc%0d: result=%h expected=%h", c, result, exp_cur);
      else passes++;
    end
  endtask

  task automatic test_stall();
    vec_t held;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < NL; i++) begin
        dataa[i] = fixed_t'((c + 1) * 4194304 / 4 + i);
        datab[i] = 27'sd4194304;
      end
      if (c >= 4 && c < 9) begin
        if (c == 4) held = exp_cur;
        step(1'b0);
        checks++;
        if (result !== held) $display("FAIL stall_hold cyc%0d: result=%h expected=%h", c, result, held);
        else passes++;
      end else begin
        step(1'b1);
        checks++;
        if (result !== exp_cur) $display("FAIL stall_stream cyc%0d: result=%h expected=%h", c, result, exp_cur);
        else passes++;
      end
    end
    dataa = '0; datab = '0;
    repeat (3) begin
      step(1'b1);
      checks++;
      if (result !== exp_cur) $display("FAIL stall_drain: result=%h expected=%h", result, exp_cur);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) begin
      drive_random();
      step(1'b1);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (result !== '0) $display("FAIL reset_mid_async: result=%h expected=0", result);
    else passes++;
    model_reset();
    drive_random();
    step(1'b1);
    checks++;
    if (result !== '0) $display("FAIL reset_mid_held: result=%h expected=0", result);
    else passes++;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_random();
      step(1'b1);
      checks++;
      if (result !== exp_cur) $display("FAIL reset_mid_after cyc%0d: result=%h expected=%h", c, result, exp_cur);
      else passes++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    passes = 0;
    model_reset();
    test_reset();
    test_identity();
    test_signed();
    test_rounding();
    test_saturation();
    test_random();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/array_mult9.md
# array_mult9

Parallel fixed-point multiplier array for the IK datapath. Accepts NLANES independent pairs of signed 27-bit fixed-point operands each enabled cycle and returns NLANES rounded, saturated products after a fixed 3-cycle pipeline. It is shared by the Jacobian computation: full_jacobian drives lanes 0–8 for its 3×3 element-wise products, and unused upper lanes are ignored.

## Interface
Parameters:
- NLANES, 12, number of independent multiplier lanes (≥9).
- WIDTH, 27, operand and result width in bits, signed two's complement.
- FRAC, 22, fractional bits of the fixed-point format. Default format is Q4.22, range [-16, 16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Clears every pipeline register.
- en  in  1  clock enable; when 0, all pipeline registers hold.
- dataa  in  NLANES×WIDTH  operand A array; dataa[i] feeds lane i.
- datab  in  NLANES×WIDTH  operand B array; datab[i] feeds lane i.
- result  out  NLANES×WIDTH  registered product array; result[i] = sat(round(dataa[i]·datab[i] >> FRAC)).

## Operation
- Lanes are fully independent. There is no cross-lane arithmetic and no lane select.
- Full product is 2·WIDTH bits, signed.
- Rounding is round-half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC. Ties on negatives round toward +∞.
- Saturation: if the rounded value exceeds 2^(WIDTH-1)-1 or is below -2^(WIDTH-1), it clamps to that bound.
- No valid/ready handshake. The consumer counts cycles itself, using the fixed latency.
- Reset value of result is all zeros. The array behaves identically for every lane index.

## Timing
- Stage 1: register dataa and datab.
- Stage 2: register the full 2·WIDTH product.
- Stage 3: register the rounded, saturated result.
- Latency is 3 enabled cycles: operands present at edge k with en=1 appear on result after edge k+2 (the third enabled edge). Throughput is one operand set per enabled cycle.
- en=0 freezes all three stages. result holds its value, and the pipeline resumes exactly where it stopped, with no data loss or duplication.
- Reset asserted (rst=0) at any time, including mid-operation, clears all stages immediately (asynchronously). result=0 while reset is held.
- After release, result stays 0 until the first operands captured post-reset have traversed 3 enabled cycles.
- Reset takes precedence over en.

## Structure
Shared package ik_pkg:
- WIDTH and FRAC constants.
- typedef fixed_t (logic signed [WIDTH-1:0]).
- typedef prod_t (2·WIDTH signed).
- Saturation bounds as constants.

Sub-modules:
- One sub-module, mult_lane, is a single 3-stage pipelined lane with round and saturate.
- array_mult9 is a generate loop of NLANES mult_lane instances sharing clk, rst and en.
- The stage-2 multiply may map to a vendor DSP multiplier, provided the behaviour is bit-exact to the Operation section.

## Test plan
- Identity: dataa[i]=4194304 (1.0), datab[i]=4194304, en=1 → result[i]=4194304 for all lanes on the 3rd enabled edge. Before that edge the result is 0.
- Signed and per-lane independence: lane 0 = -1.5·2.0 (-6291456·8388608) → -12582912; lane 1 = 0.5·0.5 → 1048576. All other lanes set to 0·x → 0.
- Rounding: 2097152·1 → 1 (half rounds up). -2097152·1 → 0. 1·1 → 0.
- Saturation: 8.0·4.0 (33554432·16777216) → 67108863. -8.0·4.0 → -67108864.
- Stall: stream distinct values on consecutive cycles, drop en for 5 cycles mid-stream → result holds. Every input appears exactly once, in order, 3 enabled cycles after capture.
- Reset mid-pipeline: pulse rst low between clock edges while data is in flight → result goes to 0 immediately. No pre-reset data appears after release.
